udma_uart_tx_buf: RTL

Parametrised, buffered UART transmitter. It is the successor to the single-character uDMA UART TX. It adds:
- a DEPTH-entry TX FIFO,
- a parametrised divisor width,
- odd/even parity selection,
- a FIFO flush and a per-character done pulse.

It sits between the uDMA TX channel and the pad, and streams characters back-to-back with no idle gap.

---
 rtl/udma_uart_tx_buf.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/udma_uart_tx_buf.sv
// Buffered UART transmitter: DEPTH-entry character FIFO feeding a start/data/parity/stop
// serialiser that chains frames back-to-back with no idle gap.
module udma_uart_tx_buf #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     cfg_en_i,
    input  logic [DIV_W-1:0]         cfg_div_i,
    input  logic                     cfg_parity_en_i,
    input  logic                     cfg_parity_odd_i,
    input  logic [1:0]               cfg_bits_i,
    input  logic                     cfg_stop_bits_i,
    input  logic                     flush_i,
    input  logic [7:0]               tx_data_i,
    input  logic                     tx_valid_i,
    output logic                     tx_ready_o,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic                     tx_done_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]       level_q, level_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [2:0]        bitc_q, bitc_d;
    logic              stop_q, stop_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [1:0]        bits_q, bits_d;
    logic              paren_q, paren_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    logic              push, pop, launch, full, empty;
    logic [7:0]        head;
    logic [7:0]        char_mask;
    logic [2:0]        last_bit;

    assign head      = mem_q[rptr_q];
    assign char_mask = 8'hFF >> (2'd3 - cfg_bits_i);
    assign last_bit  = {1'b0, bits_q} + 3'd4;
    assign push      = tx_valid_i && tx_ready_o;
    assign pop       = launch;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            bitc_q  <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            bits_q  <= '0;
            paren_q <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bitc_q  <= bitc_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            bits_q  <= bits_d;
            paren_q <= paren_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // A pop on the same edge as a flush still launches the head; only the rest is dropped.
    always_comb begin : fifo_next
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        if (flush_i) begin
            rptr_d  = wptr_q;
            level_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bitc_d  = bitc_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        bits_d  = bits_q;
        paren_d = paren_q;
        stop2_d = stop2_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        launch  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (cfg_en_i && !empty) launch = 1'b1;
            end
            ST_START: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    cnt_d   = div_q;
                    bitc_d  = '0;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    if (bitc_q == last_bit) begin
                        state_d = paren_q ? ST_PARITY : ST_STOP;
                        tx_d    = paren_q ? par_q : 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        bitc_d  = bitc_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    cnt_d   = div_q;
                    stop_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                        cnt_d  = div_q;
                    end else begin
                        done_d = 1'b1;
                        if (cfg_en_i && !empty) begin
                            launch = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Frame configuration is captured only here so mid-frame changes apply to the next character.
        if (launch) begin
            state_d = ST_START;
            tx_d    = 1'b0;
            cnt_d   = cfg_div_i;
            div_d   = cfg_div_i;
            bits_d  = cfg_bits_i;
            paren_d = cfg_parity_en_i;
            stop2_d = cfg_stop_bits_i;
            shift_d = head;
            par_d   = (^(head & char_mask)) ^ cfg_parity_odd_i;
            bitc_d  = '0;
            stop_d  = 1'b0;
        end
    end

    always_comb begin : outputs
        full         = (level_q == FULL_LVL);
        empty        = (level_q == '0);
        tx_ready_o   = !full && !flush_i;
        busy_o       = (state_q != ST_IDLE) || !empty;
        tx_o         = tx_q;
        tx_done_o    = done_q;
        fifo_level_o = level_q;
    end

endmodule
